// File: rtl/rtc_bus_seq_if.sv
// Bundle of the sequencer's request side (from the register-map controller) and its
// RTC pad side (towards the tri-state pad logic).
//   master: the sequencer itself (drives strobes, bus_out/bus_oe, read data, status)
//   slave : the controller/pad logic around it
interface rtc_bus_seq_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned BURST_W = 4
);
    logic               start;
    logic               w_r;
    logic [DATA_W-1:0]  addr;
    logic [BURST_W-1:0] burst_len;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  bus_in;
    logic               a_d;
    logic               cs;
    logic               rd;
    logic               wr;
    logic [DATA_W-1:0]  bus_out;
    logic               bus_oe;
    logic               wdata_req;
    logic [DATA_W-1:0]  rdata;
    logic               rdata_valid;
    logic               busy;
    logic               done;

    modport master (
        input  start, w_r, addr, burst_len, wdata, bus_in,
        output a_d, cs, rd, wr, bus_out, bus_oe, wdata_req, rdata, rdata_valid, busy, done
    );

    modport slave (
        output start, w_r, addr, burst_len, wdata, bus_in,
        input  a_d, cs, rd, wr, bus_out, bus_oe, wdata_req, rdata, rdata_valid, busy, done
    );
endinterface

// File: rtl/rtc_bus_seq.sv
// Bus sequencer for the RTC chip's multiplexed address/data interface. Each transfer runs
// AS -> AW -> AH -> GAP -> DW -> DH -> REC, every phase lasting its T_* cycles; bursts repeat
// the address phase with an auto-incremented register address.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   sif        : request inputs (start, w_r, addr, burst_len, wdata, bus_in) and RTC/pad
//                outputs (a_d, cs, rd, wr, bus_out, bus_oe), wdata_req, rdata, rdata_valid,
//                busy, done
module rtc_bus_seq #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned BURST_W = 4,
    parameter int unsigned T_AS    = 3,
    parameter int unsigned T_AW    = 6,
    parameter int unsigned T_AH    = 3,
    parameter int unsigned T_GAP   = 8,
    parameter int unsigned T_DW    = 8,
    parameter int unsigned T_DH    = 3,
    parameter int unsigned T_REC   = 12
) (
    input  logic          clk,
    input  logic          reset,
    rtc_bus_seq_if.master sif
);

    localparam int unsigned M1    = (T_AS > T_AW) ? T_AS : T_AW;
    localparam int unsigned M2    = (M1 > T_AH) ? M1 : T_AH;
    localparam int unsigned M3    = (M2 > T_GAP) ? M2 : T_GAP;
    localparam int unsigned M4    = (M3 > T_DW) ? M3 : T_DW;
    localparam int unsigned M5    = (M4 > T_DH) ? M4 : T_DH;
    localparam int unsigned T_MAX = (M5 > T_REC) ? M5 : T_REC;
    localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CNT_W-1:0] LAST_AS  = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] LAST_AW  = CNT_W'(T_AW - 1);
    localparam logic [CNT_W-1:0] LAST_AH  = CNT_W'(T_AH - 1);
    localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] LAST_DW  = CNT_W'(T_DW - 1);
    localparam logic [CNT_W-1:0] LAST_DH  = CNT_W'(T_DH - 1);
    localparam logic [CNT_W-1:0] LAST_REC = CNT_W'(T_REC - 1);

    typedef enum logic [2:0] {StIdle, StAs, StAw, StAh, StGap, StDw, StDh, StRec} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               phase_last;

    logic               w_r_q;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] xfer_q;

    logic accept, rec_end, final_xfer;

    logic               a_d_q, a_d_d;
    logic               cs_q, cs_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               oe_q, oe_d;
    logic [DATA_W-1:0]  bus_out_q, bus_out_d;
    logic               wdata_req_q, wdata_req_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rdata_valid_q, rdata_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    assign accept     = (state_q == StIdle) && sif.start;
    assign rec_end    = (state_q == StRec) && phase_last;
    assign final_xfer = (xfer_q == burst_q);

    always_comb begin
        phase_last = 1'b0;
        unique case (state_q)
            StAs:    phase_last = (cnt_q == LAST_AS);
            StAw:    phase_last = (cnt_q == LAST_AW);
            StAh:    phase_last = (cnt_q == LAST_AH);
            StGap:   phase_last = (cnt_q == LAST_GAP);
            StDw:    phase_last = (cnt_q == LAST_DW);
            StDh:    phase_last = (cnt_q == LAST_DH);
            StRec:   phase_last = (cnt_q == LAST_REC);
            default: phase_last = 1'b0;
        endcase
    end

    // State register and phase counter; the counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || state_q == StIdle) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (sif.start) state_d = StAs;
            StAs:    if (phase_last) state_d = StAw;
            StAw:    if (phase_last) state_d = StAh;
            StAh:    if (phase_last) state_d = StGap;
            StGap:   if (phase_last) state_d = StDw;
            StDw:    if (phase_last) state_d = StDh;
            StDh:    if (phase_last) state_d = StRec;
            StRec:   if (phase_last) state_d = final_xfer ? StIdle : StAs;
            default: state_d = StIdle;
        endcase
    end

    // Address/data shadow registers; the bus value is derived from the *_d versions so the
    // registered bus_out already shows the new address/word in the first cycle of a phase.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            addr_d  = sif.addr;
            wdata_d = sif.wdata;
        end else if (rec_end) begin
            addr_d  = addr_q + DATA_W'(1);
            wdata_d = sif.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_r_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            burst_q <= '0;
            xfer_q  <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (accept) begin
                w_r_q   <= sif.w_r;
                burst_q <= sif.burst_len;
                xfer_q  <= '0;
            end else if (rec_end) begin
                xfer_q <= xfer_q + BURST_W'(1);
            end
        end
    end

    // Output logic, decoded from the state being entered and then registered.
    always_comb begin
        a_d_d     = 1'b1;
        cs_d      = 1'b1;
        rd_d      = 1'b1;
        wr_d      = 1'b1;
        oe_d      = 1'b0;
        bus_out_d = '0;
        unique case (state_d)
            StAs: begin
                a_d_d     = 1'b0;
                oe_d      = 1'b1;
                bus_out_d = addr_d;
            end
            StAw: begin
                a_d_d     = 1'b0;
                cs_d      = 1'b0;
                wr_d      = 1'b0;
                oe_d      = 1'b1;
                bus_out_d = addr_d;
            end
            StAh: begin
                a_d_d     = 1'b0;
                oe_d      = 1'b1;
                bus_out_d = addr_d;
            end
            StDw: begin
                cs_d = 1'b0;
                if (w_r_q) begin
                    wr_d      = 1'b0;
                    oe_d      = 1'b1;
                    bus_out_d = wdata_d;
                end else begin
                    rd_d = 1'b0;
                end
            end
            StDh: begin
                if (w_r_q) begin
                    oe_d      = 1'b1;
                    bus_out_d = wdata_d;
                end
            end
            default: ;
        endcase

        wdata_req_d   = (state_q == StDh) && phase_last && w_r_q && !final_xfer;
        rdata_valid_d = (state_q == StDw) && phase_last && !w_r_q;
        rdata_d       = rdata_valid_d ? sif.bus_in : rdata_q;
        busy_d        = (state_d != StIdle);
        done_d        = rec_end && final_xfer;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_d_q         <= 1'b1;
            cs_q          <= 1'b1;
            rd_q          <= 1'b1;
            wr_q          <= 1'b1;
            oe_q          <= 1'b0;
            bus_out_q     <= '0;
            wdata_req_q   <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            a_d_q         <= a_d_d;
            cs_q          <= cs_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            oe_q          <= oe_d;
            bus_out_q     <= bus_out_d;
            wdata_req_q   <= wdata_req_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign sif.a_d         = a_d_q;
    assign sif.cs          = cs_q;
    assign sif.rd          = rd_q;
    assign sif.wr          = wr_q;
    assign sif.bus_oe      = oe_q;
    assign sif.bus_out     = bus_out_q;
    assign sif.wdata_req   = wdata_req_q;
    assign sif.rdata       = rdata_q;
    assign sif.rdata_valid = rdata_valid_q;
    assign sif.busy        = busy_q;
    assign sif.done        = done_q;

endmodule

// File: doc/rtc_bus_seq.md
# rtc_bus_seq

Parametrised bus sequencer for the multiplexed address/data interface of the real-time-clock chip. It generates the `a_d`, `cs`, `rd` and `wr` strobes, drives and releases the shared bus, and captures read data. It supports single or burst transfers, with the register address auto-incremented between transfers. It sits between the RTC register-map controller and the top-level tri-state pad logic.

## Interface
Parameters:
- `DATA_W`, 8: width of the multiplexed address/data bus, `addr` and data words.
- `BURST_W`, 4: width of `burst_len`.
- `T_AS`, 3: cycles with `a_d` low before the address strobe (address setup).
- `T_AW`, 6: address strobe width (`cs` and `wr` low).
- `T_AH`, 3: address hold after the strobe.
- `T_GAP`, 8: cycles with `a_d` high and the bus released before the data strobe.
- `T_DW`, 8: data strobe width.
- `T_DH`, 3: data hold after the strobe.
- `T_REC`, 12: recovery cycles before the next transfer or idle.
- Every `T_*` is ≥1.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `w_r`  in  1  1 = write, 0 = read; latched at start.
- `addr`  in  DATA_W  first register address; latched at start.
- `burst_len`  in  BURST_W  number of transfers minus 1; latched at start.
- `wdata`  in  DATA_W  write word.
- `bus_in`  in  DATA_W  value read from the pads.
- `a_d`, `cs`, `rd`, `wr`  out  1 each  RTC control lines, all active-low except `a_d` (1 = data phase).
- `bus_out`  out  DATA_W  value driven onto the pads.
- `bus_oe`  out  1  pad output enable.
- `wdata_req`  out  1  one-cycle request for the next write word.
- `rdata`  out  DATA_W  captured read word.
- `rdata_valid`  out  1  one-cycle pulse marking a new `rdata`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse at burst completion.

## Operation
- States: IDLE → AS → AW → AH → GAP → DW → DH → REC. From REC the FSM goes to AS if transfers remain, otherwise to IDLE. Every transfer repeats the address phase.
- A single phase counter (width `$clog2` of the maximum `T_*`) clears on each state entry. Each state lasts exactly its `T_*` cycles.
- Outputs per state (registered, glitch-free):
  - IDLE: `a_d`=1, `cs`=`rd`=`wr`=1, `bus_oe`=0.
  - AS: `a_d`=0, `bus_oe`=1, `bus_out`=current address.
  - AW: as AS, plus `cs`=0 and `wr`=0.
  - AH: `cs`=`wr`=1; the address is still driven.
  - GAP: `a_d`=1, `bus_oe`=0.
  - DW, write: `cs`=0, `wr`=0, `bus_oe`=1, `bus_out`=data word.
  - DW, read: `cs`=0, `rd`=0, `bus_oe`=0.
  - DH: strobes high; the write data stays driven, `bus_oe`=0 for reads.
  - REC: strobes high, `bus_oe`=0.
- Start: in IDLE with `start`=1, the block latches `w_r`, `addr`, `burst_len`, and `wdata` as the first write word.
- Address increment: the current address increments modulo 2^DATA_W after each transfer; 0xFF wraps to 0x00.
- Write bursts: `wdata_req` pulses in the first REC cycle of every non-final transfer. `wdata` is latched on the last REC cycle.
- Reads: `bus_in` is registered into `rdata` on the last DW cycle. `rdata_valid` pulses in the first DH cycle.
- Completion: `done` pulses in the first IDLE cycle after the final REC.
- `start` while busy is ignored. `start` is accepted in the same cycle as the `done` pulse.
- Reset reaction: `reset` at any point, including mid-burst, forces IDLE on the next edge. All outputs take their IDLE values, `rdata` clears to 0, pulses drop, and no `done` is issued.

## Timing
- Reset values: `a_d`=`cs`=`rd`=`wr`=1; `bus_oe`, `bus_out`, `rdata`, `rdata_valid`, `wdata_req`, `busy` and `done` all 0.
- `start` sampled at edge k:
  - `busy` and AS begin in cycle k+1.
  - `a_d` falls in cycle k+1.
  - `cs` falls in cycle k+1+T_AS.
- One transfer lasts S = T_AS+T_AW+T_AH+T_GAP+T_DW+T_DH+T_REC cycles (43 at defaults).
- A burst of N transfers holds `busy` high for N·S cycles. `done` appears in cycle k+1+N·S.
- `bus_oe` drops in the same cycle that `a_d` rises, which avoids contention with the RTC.

## Test plan
- Single write, defaults: addr=0x21, wdata=0x5A, burst_len=0.
  - `cs`/`wr` low during cycles k+4..k+9 with `bus_out`=0x21.
  - `cs`/`wr` low during cycles k+21..k+28 with `bus_out`=0x5A.
  - `done` in cycle k+44.
- Single read: addr=0x10, `bus_in`=0xC3 during DW.
  - `rd` low for 8 cycles and `bus_oe`=0 throughout the data phase.
  - `rdata`=0xC3 with `rdata_valid` pulsing exactly once.
- Burst write: addr=0xFE, burst_len=2.
  - Addresses driven are 0xFE, 0xFF, 0x00.
  - Exactly two `wdata_req` pulses; the supplied words appear on the bus in order.
  - `busy` is high for 129 cycles.
- `start` pulsed while busy: no effect on the bus sequence. A `start` coincident with `done` begins a new transfer the following cycle.
- `reset` asserted during the DW of transfer 2 of a 4-transfer read burst:
  - Next cycle shows the IDLE outputs, `rdata`=0, and no `done`.
  - A new `start` then proceeds normally.
- All `T_*`=1, 3-transfer read: each transfer lasts 7 cycles, and `rdata_valid` pulses in cycles k+6, k+13 and k+20.
